// File: rtl/snes_pkg.sv
// Shared definitions for the NES/SNES controller datapath.
// Holds the button bit map, source and arbiter-state encodings, and the
// SOCD (opposing-direction) cleaning helper used at the output load.
package snes_pkg;

  localparam int unsigned BTN_W     = 12;
  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_START = 4;
  localparam int unsigned BTN_SEL   = 5;
  localparam int unsigned BTN_A     = 6;
  localparam int unsigned BTN_B     = 7;
  localparam int unsigned BTN_X     = 8;
  localparam int unsigned BTN_Y     = 9;
  localparam int unsigned BTN_L     = 10;
  localparam int unsigned BTN_R     = 11;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BB   = 2'd1,
    SRC_N64  = 2'd2,
    SRC_REM  = 2'd3
  } src_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_BB  = 2'd1,
    ST_OWN_N64 = 2'd2,
    ST_OWN_REM = 2'd3
  } arb_state_t;

  // Opposing directions pressed together cancel each other out.
  function automatic logic [BTN_W-1:0] socd_filter(input logic [BTN_W-1:0] v);
    logic [BTN_W-1:0] r;
    r = v;
    if (v[BTN_UP] && v[BTN_DOWN]) begin
      r[BTN_UP]   = 1'b0;
      r[BTN_DOWN] = 1'b0;
    end
    if (v[BTN_LEFT] && v[BTN_RIGHT]) begin
      r[BTN_LEFT]  = 1'b0;
      r[BTN_RIGHT] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/input_source_arbiter_source_monitor.sv
// source_monitor: per-source capture register and staleness tracker.
// Ports:
//   clk, reset (sync, active-low)
//   buttons/valid   : incoming vector and its 1-cycle frame strobe
//   eff_buttons     : captured vector, forced to 0 while stale
//   active          : any effective button pressed
//   stale           : no strobe seen for STALE_CYCLES cycles
module source_monitor
  import snes_pkg::*;
#(
  parameter int unsigned STALE_CYCLES = 600_000,
  parameter int unsigned CNT_W        = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BTN_W-1:0] buttons,
  input  logic             valid,
  output logic [BTN_W-1:0] eff_buttons,
  output logic             active,
  output logic             stale
);

  logic [BTN_W-1:0] cap_q, cap_d;
  logic [CNT_W-1:0] stale_cnt_q, stale_cnt_d;

  // A strobe wins over saturation in the same cycle.
  always_comb begin
    cap_d       = cap_q;
    stale_cnt_d = stale_cnt_q;
    if (valid) begin
      cap_d       = buttons;
      stale_cnt_d = '0;
    end else if (stale_cnt_q != CNT_W'(STALE_CYCLES)) begin
      stale_cnt_d = stale_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cap_q       <= '0;
      stale_cnt_q <= CNT_W'(STALE_CYCLES);
    end else begin
      cap_q       <= cap_d;
      stale_cnt_q <= stale_cnt_d;
    end
  end

  assign stale       = (stale_cnt_q == CNT_W'(STALE_CYCLES));
  assign eff_buttons = stale ? '0 : cap_q;
  assign active      = |eff_buttons;

endmodule

// File: rtl/input_source_arbiter.sv
// input_source_arbiter: shares the NES/SNES serializer between the button
// board, N64 receiver and remote receiver.
// Ports:
//   clk, reset (sync, active-low)
//   bb_/n64_/rem_buttons, *_valid : source vectors and frame strobes
//   latch       : console latch, already synchronised
//   buttons_out : frame-coherent vector, updated only on latch falling edge
//   active_src  : 0 none, 1 bb, 2 n64, 3 remote
//   src_switch  : 1-cycle pulse when active_src changes
module input_source_arbiter
  import snes_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 1_200_000,
  parameter int unsigned STALE_CYCLES = 600_000,
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned SOCD_CLEAN   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BTN_W-1:0] bb_buttons,
  input  logic             bb_valid,
  input  logic [BTN_W-1:0] n64_buttons,
  input  logic             n64_valid,
  input  logic [BTN_W-1:0] rem_buttons,
  input  logic             rem_valid,
  input  logic             latch,
  output logic [BTN_W-1:0] buttons_out,
  output logic [1:0]       active_src,
  output logic             src_switch
);

  logic [BTN_W-1:0] bb_eff, n64_eff, rem_eff;
  logic             bb_act, n64_act, rem_act;
  logic             bb_stale, n64_stale, rem_stale;

  source_monitor #(.STALE_CYCLES(STALE_CYCLES), .CNT_W(CNT_W)) u_mon_bb (
    .clk(clk), .reset(reset), .buttons(bb_buttons), .valid(bb_valid),
    .eff_buttons(bb_eff), .active(bb_act), .stale(bb_stale)
  );
  source_monitor #(.STALE_CYCLES(STALE_CYCLES), .CNT_W(CNT_W)) u_mon_n64 (
    .clk(clk), .reset(reset), .buttons(n64_buttons), .valid(n64_valid),
    .eff_buttons(n64_eff), .active(n64_act), .stale(n64_stale)
  );
  source_monitor #(.STALE_CYCLES(STALE_CYCLES), .CNT_W(CNT_W)) u_mon_rem (
    .clk(clk), .reset(reset), .buttons(rem_buttons), .valid(rem_valid),
    .eff_buttons(rem_eff), .active(rem_act), .stale(rem_stale)
  );

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  src_t             active_src_q, active_src_d;
  logic             src_switch_q, src_switch_d;
  logic             latch_q;
  logic [BTN_W-1:0] buttons_q, buttons_d;

  logic [BTN_W-1:0] own_vec;
  logic             own_act, own_stale, latch_fall;

  // Current owner view, taken from the registered state so a load on the
  // same edge as a state change still uses the pre-change owner.
  always_comb begin
    own_vec   = '0;
    own_act   = 1'b0;
    own_stale = 1'b0;
    case (state_q)
      ST_OWN_BB:  begin own_vec = bb_eff;  own_act = bb_act;  own_stale = bb_stale;  end
      ST_OWN_N64: begin own_vec = n64_eff; own_act = n64_act; own_stale = n64_stale; end
      ST_OWN_REM: begin own_vec = rem_eff; own_act = rem_act; own_stale = rem_stale; end
      default:    ;
    endcase
  end

  // Grants only leave IDLE, releases only enter it, so IDLE always lasts a cycle.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        hold_d = '0;
        if (bb_act)       state_d = ST_OWN_BB;
        else if (n64_act) state_d = ST_OWN_N64;
        else if (rem_act) state_d = ST_OWN_REM;
      end
      default: begin
        if (own_stale) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else if (own_act) begin
          hold_d = '0;
        end else if (hold_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    case (state_d)
      ST_OWN_BB:  active_src_d = SRC_BB;
      ST_OWN_N64: active_src_d = SRC_N64;
      ST_OWN_REM: active_src_d = SRC_REM;
      default:    active_src_d = SRC_NONE;
    endcase
    src_switch_d = (active_src_d != active_src_q);
  end

  assign latch_fall = ~latch & latch_q;

  always_comb begin
    buttons_d = buttons_q;
    if (latch_fall) begin
      buttons_d = (SOCD_CLEAN != 0) ? socd_filter(own_vec) : own_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      active_src_q <= SRC_NONE;
      src_switch_q <= 1'b0;
      latch_q      <= 1'b0;
      buttons_q    <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      active_src_q <= active_src_d;
      src_switch_q <= src_switch_d;
      latch_q      <= latch;
      buttons_q    <= buttons_d;
    end
  end

  assign buttons_out = buttons_q;
  assign active_src  = active_src_q;
  assign src_switch  = src_switch_q;

endmodule

// File: tb/tb_input_source_arbiter.sv
module tb_input_source_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] bb_buttons, n64_buttons, rem_buttons;
  logic        bb_valid, n64_valid, rem_valid, latch;
  logic [11:0] buttons_out, buttons_out_ns;
  logic [1:0]  active_src, active_src_ns;
  logic        src_switch, src_switch_ns;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  input_source_arbiter #(.HOLD_CYCLES(16), .STALE_CYCLES(32), .CNT_W(24), .SOCD_CLEAN(1)) dut (
    .clk(clk), .reset(reset),
    .bb_buttons(bb_buttons), .bb_valid(bb_valid),
    .n64_buttons(n64_buttons), .n64_valid(n64_valid),
    .rem_buttons(rem_buttons), .rem_valid(rem_valid),
    .latch(latch), .buttons_out(buttons_out),
    .active_src(active_src), .src_switch(src_switch)
  );

  input_source_arbiter #(.HOLD_CYCLES(16), .STALE_CYCLES(32), .CNT_W(24), .SOCD_CLEAN(0)) dut_ns (
    .clk(clk), .reset(reset),
    .bb_buttons(bb_buttons), .bb_valid(bb_valid),
    .n64_buttons(n64_buttons), .n64_valid(n64_valid),
    .rem_buttons(rem_buttons), .rem_valid(rem_valid),
    .latch(latch), .buttons_out(buttons_out_ns),
    .active_src(active_src_ns), .src_switch(src_switch_ns)
  );

  typedef struct {
    int          src;      // 1 bb, 2 n64, 3 remote
    logic [11:0] vec;
    logic [1:0]  exp_act;
    logic [11:0] exp_clean;
    logic [11:0] exp_raw;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%03h expected 0x%03h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bb_valid = 0; n64_valid = 0; rem_valid = 0; latch = 0;
    reset = 0;
    tick(2);
    reset = 1;
  endtask

  // Strobe applied for one cycle; returns at the negedge after capture.
  task automatic strobe(input int s, input logic [11:0] v);
    case (s)
      1: begin bb_buttons = v;  bb_valid = 1;  end
      2: begin n64_buttons = v; n64_valid = 1; end
      default: begin rem_buttons = v; rem_valid = 1; end
    endcase
    tick(1);
    bb_valid = 0; n64_valid = 0; rem_valid = 0;
  endtask

  // Returns at the first negedge where the post-fall value is visible.
  task automatic latch_pulse();
    latch = 1;
    tick(1);
    latch = 0;
    tick(1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    bb_buttons = '0; n64_buttons = '0; rem_buttons = '0;

    // Table: single source after reset, one grant, one latch load.
    tbl[0] = '{1, 12'h040, 2'd1, 12'h040, 12'h040};
    tbl[1] = '{2, 12'h010, 2'd2, 12'h010, 12'h010};
    tbl[2] = '{3, 12'h00F, 2'd3, 12'h000, 12'h00F};
    tbl[3] = '{3, 12'h005, 2'd3, 12'h005, 12'h005};
    tbl[4] = '{3, 12'h003, 2'd3, 12'h000, 12'h003};
    tbl[5] = '{1, 12'h80C, 2'd1, 12'h800, 12'h80C};
    tbl[6] = '{2, 12'hFFF, 2'd2, 12'hFF0, 12'hFFF};
    tbl[7] = '{1, 12'h000, 2'd0, 12'h000, 12'h000};
    tbl[8] = '{3, 12'h0CA, 2'd3, 12'h0CA, 12'h0CA};

    // 1: reset state and latch pulses with no sources
    do_reset();
    tick(1);
    chk("reset_out", buttons_out, 12'h000);
    chk("reset_src", {10'd0, active_src}, 12'h000);
    chk("reset_switch", {11'd0, src_switch}, 12'h000);
    latch_pulse();
    latch_pulse();
    chk("idle_latch_out", buttons_out, 12'h000);
    chk("idle_latch_src", {10'd0, active_src}, 12'h000);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      strobe(tbl[i].src, tbl[i].vec);
      tick(1);
      chk($sformatf("tbl%0d_src", i), {10'd0, active_src}, {10'd0, tbl[i].exp_act});
      latch_pulse();
      chk($sformatf("tbl%0d_clean", i), buttons_out, tbl[i].exp_clean);
      chk($sformatf("tbl%0d_raw", i), buttons_out_ns, tbl[i].exp_raw);
    end

    // 2: bb owns, output frozen while latch high
    do_reset();
    bb_buttons = '0; n64_buttons = '0; rem_buttons = '0;
    strobe(1, 12'h040);
    tick(1);
    chk("bb_grant", {10'd0, active_src}, 12'h001);
    chk("bb_switch", {11'd0, src_switch}, 12'h001);
    tick(1);
    chk("bb_switch_low", {11'd0, src_switch}, 12'h000);
    latch = 1;
    tick(1);
    chk("latch_high_hold", buttons_out, 12'h000);
    latch = 0;
    tick(1);
    chk("bb_load", buttons_out, 12'h040);

    // 3: n64 active but no pre-emption; bb idle hold then handover
    strobe(2, 12'h010);
    tick(2);
    chk("no_preempt", {10'd0, active_src}, 12'h001);
    strobe(1, 12'h000);
    tick(15);
    chk("hold_still_bb", {10'd0, active_src}, 12'h001);
    tick(1);
    chk("release_idle", {10'd0, active_src}, 12'h000);
    chk("release_switch", {11'd0, src_switch}, 12'h001);
    tick(1);
    chk("n64_grant", {10'd0, active_src}, 12'h002);
    chk("n64_switch", {11'd0, src_switch}, 12'h001);

    // 4: n64 owns, then stops strobing and goes stale
    strobe(2, 12'h010);
    c0 = cyc;
    latch_pulse();
    chk("n64_load", buttons_out, 12'h010);
    // Counter saturates 32 edges after the strobe edge; FSM leaves on the next.
    for (int k = 0; k < 60 && active_src != 2'd0; k++) tick(1);
    chk("stale_release_cycle", 12'(cyc - c0), 12'd33);
    chk("stale_idle", {10'd0, active_src}, 12'h000);
    latch_pulse();
    chk("stale_load_zero", buttons_out, 12'h000);

    // 6: reset mid-shift
    do_reset();
    strobe(1, 12'h0C0);
    tick(1);
    latch_pulse();
    chk("pre_reset_load", buttons_out, 12'h0C0);
    latch = 1;
    tick(1);
    reset = 0;
    tick(1);
    chk("midreset_out", buttons_out, 12'h000);
    chk("midreset_src", {10'd0, active_src}, 12'h000);
    chk("midreset_switch", {11'd0, src_switch}, 12'h000);
    reset = 1;
    latch = 0;
    tick(2);
    chk("post_reset_stale_src", {10'd0, active_src}, 12'h000);
    chk("post_reset_out", buttons_out, 12'h000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
